axis_dot_share_arb: RTL and testbench

//  Shares one axis_dot_4_4 matrix-vector engine between two AXI4-Stream requesters.

---
 rtl/axis_dot_share_arb.sv | 174 +++++++++++++++++
 tb/tb_axis_dot_share_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dot_share_arb.sv
// Round-robin sharing of one matrix-vector engine between two AXI4-Stream requesters.
// One whole job (IN_LEN words in, OUT_LEN results out) is granted at a time.
module axis_dot_share_arb #(
    parameter int DATA_W  = 32,
    parameter int IN_LEN  = 4,
    parameter int OUT_LEN = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] S0_AXIS_TDATA,
    input  logic              S0_AXIS_TLAST,
    input  logic              S0_AXIS_TVALID,
    output logic              S0_AXIS_TREADY,
    input  logic [DATA_W-1:0] S1_AXIS_TDATA,
    input  logic              S1_AXIS_TLAST,
    input  logic              S1_AXIS_TVALID,
    output logic              S1_AXIS_TREADY,
    output logic [DATA_W-1:0] ENG_IN_TDATA,
    output logic              ENG_IN_TLAST,
    output logic              ENG_IN_TVALID,
    input  logic              ENG_IN_TREADY,
    input  logic [DATA_W-1:0] ENG_OUT_TDATA,
    input  logic              ENG_OUT_TLAST,
    input  logic              ENG_OUT_TVALID,
    output logic              ENG_OUT_TREADY,
    output logic [DATA_W-1:0] M0_AXIS_TDATA,
    output logic              M0_AXIS_TLAST,
    output logic              M0_AXIS_TVALID,
    input  logic              M0_AXIS_TREADY,
    output logic [DATA_W-1:0] M1_AXIS_TDATA,
    output logic              M1_AXIS_TLAST,
    output logic              M1_AXIS_TVALID,
    input  logic              M1_AXIS_TREADY,
    output logic              busy,
    output logic              grant
);

    localparam int MAX_LEN = (IN_LEN > OUT_LEN) ? IN_LEN : OUT_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] IN_LAST  = CW'(IN_LEN - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'(OUT_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          in_hs_s;
    logic          out_hs_s;
    logic          unused_tlast_s;

    // Jobs are length-counted, so incoming TLAST flags carry no information.
    assign unused_tlast_s = S0_AXIS_TLAST ^ S1_AXIS_TLAST ^ ENG_OUT_TLAST;

    assign in_hs_s  = ENG_IN_TVALID & ENG_IN_TREADY;
    assign out_hs_s = ENG_OUT_TVALID & ENG_OUT_TREADY;
    assign busy     = (state_q != ST_IDLE);
    assign grant    = grant_q;

    // State, grant and job counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b1;
            last_grant_q <= 1'b1;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, then count input and result handshakes.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
                    grant_d = ~last_grant_q;
                    state_d = ST_FWD;
                end else if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
                    grant_d = S1_AXIS_TVALID;
                    state_d = ST_FWD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (in_hs_s && (in_cnt_q == IN_LAST)) begin
                    in_cnt_d     = '0;
                    state_d      = ST_RSP;
                    last_grant_d = grant_q;
                end else if (in_hs_s) begin
                    in_cnt_d = in_cnt_q + CNT_ONE;
                end else begin
                    in_cnt_d = in_cnt_q;
                end
            end
            ST_RSP: begin
                if (out_hs_s && (out_cnt_q == OUT_LAST)) begin
                    out_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (out_hs_s) begin
                    out_cnt_d = out_cnt_q + CNT_ONE;
                end else begin
                    out_cnt_d = out_cnt_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                in_cnt_d  = '0;
                out_cnt_d = '0;
            end
        endcase
    end

    // Zero-latency routing; everything not owned by the granted path stays quiet.
    always_comb begin
        S0_AXIS_TREADY = 1'b0;
        S1_AXIS_TREADY = 1'b0;
        ENG_IN_TDATA   = grant_q ? S1_AXIS_TDATA : S0_AXIS_TDATA;
        ENG_IN_TLAST   = 1'b0;
        ENG_IN_TVALID  = 1'b0;
        ENG_OUT_TREADY = 1'b0;
        M0_AXIS_TDATA  = ENG_OUT_TDATA;
        M1_AXIS_TDATA  = ENG_OUT_TDATA;
        M0_AXIS_TLAST  = 1'b0;
        M1_AXIS_TLAST  = 1'b0;
        M0_AXIS_TVALID = 1'b0;
        M1_AXIS_TVALID = 1'b0;
        case (state_q)
            ST_FWD: begin
                ENG_IN_TLAST = (in_cnt_q == IN_LAST);
                if (grant_q) begin
                    ENG_IN_TVALID  = S1_AXIS_TVALID;
                    S1_AXIS_TREADY = ENG_IN_TREADY;
                end else begin
                    ENG_IN_TVALID  = S0_AXIS_TVALID;
                    S0_AXIS_TREADY = ENG_IN_TREADY;
                end
            end
            ST_RSP: begin
                if (grant_q) begin
                    M1_AXIS_TVALID = ENG_OUT_TVALID;
                    M1_AXIS_TLAST  = (out_cnt_q == OUT_LAST);
                    ENG_OUT_TREADY = M1_AXIS_TREADY;
                end else begin
                    M0_AXIS_TVALID = ENG_OUT_TVALID;
                    M0_AXIS_TLAST  = (out_cnt_q == OUT_LAST);
                    ENG_OUT_TREADY = M0_AXIS_TREADY;
                end
            end
            default: begin
                ENG_IN_TVALID = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_dot_share_arb.sv
// Bench for axis_dot_share_arb: behavioural engine model, per-requester scoreboards,
// a table of job scenarios plus a mid-job reset sequence.
module tb_axis_dot_share_arb;

    localparam int DW  = 32;
    localparam int LEN = 4;
    localparam logic [DW-1:0] K = 32'h0001_0101;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [1:0][DW-1:0] s_data, m_data;
    logic [1:0] s_last, s_valid, s_ready, m_last, m_valid, m_ready;
    logic [DW-1:0] ei_data, eo_data;
    logic ei_last, ei_valid, ei_ready, eo_last, eo_valid, eo_ready;
    logic busy, grant;

    axis_dot_share_arb #(.DATA_W(DW), .IN_LEN(LEN), .OUT_LEN(LEN)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .S0_AXIS_TDATA(s_data[0]), .S0_AXIS_TLAST(s_last[0]),
        .S0_AXIS_TVALID(s_valid[0]), .S0_AXIS_TREADY(s_ready[0]),
        .S1_AXIS_TDATA(s_data[1]), .S1_AXIS_TLAST(s_last[1]),
        .S1_AXIS_TVALID(s_valid[1]), .S1_AXIS_TREADY(s_ready[1]),
        .ENG_IN_TDATA(ei_data), .ENG_IN_TLAST(ei_last),
        .ENG_IN_TVALID(ei_valid), .ENG_IN_TREADY(ei_ready),
        .ENG_OUT_TDATA(eo_data), .ENG_OUT_TLAST(eo_last),
        .ENG_OUT_TVALID(eo_valid), .ENG_OUT_TREADY(eo_ready),
        .M0_AXIS_TDATA(m_data[0]), .M0_AXIS_TLAST(m_last[0]),
        .M0_AXIS_TVALID(m_valid[0]), .M0_AXIS_TREADY(m_ready[0]),
        .M1_AXIS_TDATA(m_data[1]), .M1_AXIS_TLAST(m_last[1]),
        .M1_AXIS_TVALID(m_valid[1]), .M1_AXIS_TREADY(m_ready[1]),
        .busy(busy), .grant(grant)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int n0; int n1; int gap; int rdy; int stall;
        int chk_grant; int chk_gap; int ng; logic [5:0] grants;
    } row_t;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] src0_q[$], src1_q[$], eng_buf[$], eng_out_q[$];
    beat_t exp0_q[$], exp1_q[$];
    int exp_grant_q[$];
    int gap_en, rdy_mode, stall_en, chk_grant, chk_gap;
    int idle_len, jobs_done, in_hs_total;
    logic busy_prev;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Queue one job for requester r and its expected results.
    task automatic push_job(input int r);
        logic [DW-1:0] w;
        logic [DW-1:0] sum;
        beat_t b;
        sum = '0;
        for (int k = 0; k < LEN; k++) begin
            w = $urandom;
            sum = sum + w;
            if (r == 0) src0_q.push_back(w); else src1_q.push_back(w);
        end
        for (int j = 0; j < LEN; j++) begin
            b.data = sum + K * 32'(j + 1);
            b.last = (j == LEN - 1);
            if (r == 0) exp0_q.push_back(b); else exp1_q.push_back(b);
        end
    endtask

    task automatic check_result(input int r);
        beat_t b;
        if (((r == 0) ? exp0_q.size() : exp1_q.size()) == 0) begin
            check("m_unexpected", 32'd1, 32'd0);
        end else begin
            b = (r == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            check((r == 0) ? "m0_data" : "m1_data", m_data[r], b.data);
            check((r == 0) ? "m0_tlast" : "m1_tlast", 32'(m_last[r]), 32'(b.last));
        end
    endtask

    // One clock: drive at negedge, observe 1ns later, handshakes land on the posedge.
    task automatic cycle();
        logic [DW-1:0] sum;
        @(negedge aclk);
        s_valid[0] = (src0_q.size() > 0) && (gap_en == 0 || $urandom_range(0, 2) != 0);
        s_valid[1] = (src1_q.size() > 0) && (gap_en == 0 || $urandom_range(0, 2) != 0);
        s_data[0]  = (src0_q.size() > 0) ? src0_q[0] : '0;
        s_data[1]  = (src1_q.size() > 0) ? src1_q[0] : '0;
        s_last     = 2'($urandom);
        for (int r = 0; r < 2; r++) begin
            if (rdy_mode == 1) m_ready[r] = ~m_ready[r];
            else if (rdy_mode == 2) m_ready[r] = 1'($urandom);
            else m_ready[r] = 1'b1;
        end
        ei_ready = (eng_buf.size() < LEN) && (eng_out_q.size() == 0)
                   && (stall_en == 0 || $urandom_range(0, 3) != 0);
        eo_valid = (eng_out_q.size() > 0);
        eo_data  = eo_valid ? eng_out_q[0] : '0;
        eo_last  = (eng_out_q.size() == 1);
        #1;
        check("m0_route", 32'(m_valid[0] && !(busy && grant == 1'b0)), 32'd0);
        check("m1_route", 32'(m_valid[1] && !(busy && grant == 1'b1)), 32'd0);
        check("s0_route", 32'(s_ready[0] && !(busy && grant == 1'b0)), 32'd0);
        check("s1_route", 32'(s_ready[1] && !(busy && grant == 1'b1)), 32'd0);
        check("eng_out_idle", 32'(eo_ready && !busy), 32'd0);
        if (busy && !busy_prev) begin
            if (chk_gap != 0 && jobs_done > 0) check("idle_gap", 32'(idle_len), 32'd1);
            if (chk_grant != 0) begin
                if (exp_grant_q.size() == 0) check("grant_extra", 32'd1, 32'd0);
                else check("grant_order", 32'(grant), 32'(exp_grant_q.pop_front()));
            end
        end
        if (!busy && busy_prev) jobs_done++;
        idle_len = busy ? 0 : idle_len + 1;
        if (s_valid[0] && s_ready[0]) void'(src0_q.pop_front());
        if (s_valid[1] && s_ready[1]) void'(src1_q.pop_front());
        if (ei_valid && ei_ready) begin
            in_hs_total++;
            eng_buf.push_back(ei_data);
            check("eng_in_tlast", 32'(ei_last), 32'(eng_buf.size() == LEN));
            if (eng_buf.size() == LEN) begin
                sum = '0;
                foreach (eng_buf[k]) sum = sum + eng_buf[k];
                for (int j = 0; j < LEN; j++) eng_out_q.push_back(sum + K * 32'(j + 1));
                eng_buf.delete();
            end
        end
        if (eo_valid && eo_ready) void'(eng_out_q.pop_front());
        for (int r = 0; r < 2; r++) begin
            if (m_valid[r] && m_ready[r]) check_result(r);
        end
        busy_prev = busy;
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("rst_quiet", {26'd0, s_ready, m_valid, ei_valid, eo_ready}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd1);
        src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
        eng_buf.delete(); eng_out_q.delete(); exp_grant_q.delete();
        s_valid = 2'b00; m_ready = 2'b00; ei_ready = 1'b0; eo_valid = 1'b0;
        idle_len = 0; jobs_done = 0; busy_prev = 1'b0; in_hs_total = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic run_to_idle(input string name);
        int cyc;
        cyc = 0;
        while ((src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size()
                + eng_buf.size() + eng_out_q.size() > 0 || busy) && cyc < 3000) begin
            cycle();
            cyc++;
        end
        check({name, "_done"}, 32'(cyc < 3000), 32'd1);
        check({name, "_grants_seen"}, 32'(exp_grant_q.size()), 32'd0);
    endtask

    row_t rows[7];

    initial begin
        int cyc;
        rows[0] = '{1, 0, 0, 0, 0, 1, 0, 1, 6'b000000};
        rows[1] = '{1, 1, 0, 0, 0, 1, 1, 2, 6'b000010};
        rows[2] = '{3, 3, 0, 0, 0, 1, 1, 6, 6'b101010};
        rows[3] = '{0, 2, 0, 0, 0, 1, 1, 2, 6'b000011};
        rows[4] = '{1, 0, 1, 1, 0, 1, 0, 1, 6'b000000};
        rows[5] = '{2, 2, 1, 2, 1, 0, 0, 0, 6'b000000};
        rows[6] = '{2, 0, 0, 1, 1, 1, 1, 2, 6'b000000};
        s_data = '0; s_last = '0; s_valid = '0; m_ready = '0;
        ei_ready = 1'b0; eo_valid = 1'b0; eo_data = '0; eo_last = 1'b0;
        gap_en = 0; rdy_mode = 0; stall_en = 0; chk_grant = 0; chk_gap = 0;

        for (int i = 0; i < 7; i++) begin
            apply_reset();
            gap_en = rows[i].gap; rdy_mode = rows[i].rdy; stall_en = rows[i].stall;
            chk_grant = rows[i].chk_grant; chk_gap = rows[i].chk_gap;
            for (int g = 0; g < rows[i].ng; g++) exp_grant_q.push_back(int'(rows[i].grants[g]));
            for (int n = 0; n < rows[i].n0; n++) push_job(0);
            for (int n = 0; n < rows[i].n1; n++) push_job(1);
            run_to_idle($sformatf("row%0d", i));
        end

        // Reset after two words of an S0 job, then a fresh S0 job must go through.
        apply_reset();
        gap_en = 0; rdy_mode = 0; stall_en = 0; chk_grant = 1; chk_gap = 0;
        exp_grant_q.push_back(0);
        push_job(0);
        cyc = 0;
        while (in_hs_total < 2 && cyc < 200) begin
            cycle();
            cyc++;
        end
        check("midjob_reached", 32'(in_hs_total), 32'd2);
        check("midjob_busy", 32'(busy), 32'd1);
        apply_reset();
        chk_grant = 1;
        exp_grant_q.push_back(0);
        push_job(0);
        run_to_idle("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
